// File: rtl/sram_arbiter.sv
// sram_arbiter: N-channel valid/ready arbiter with a one-entry response buffer per channel, in front of a 1-cycle single-port SRAM.
// Latency: grant and SRAM drive are combinational; read data is in rsp_data two cycles after the grant.
// Backpressure: an untaken response holds its buffer and blocks that channel's reads; writes are never blocked.
module sram_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH-1:0]          req_we,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] req_wstrb,
    output logic [NUM_CH-1:0]          rsp_valid,
    input  logic [NUM_CH-1:0]          rsp_ready,
    output logic [NUM_CH*DATA_W-1:0]   rsp_data,
    output logic                       sram_ceb,
    output logic                       sram_web,
    output logic [DATA_W-1:0]          sram_bweb,
    output logic [ADDR_W-1:0]          sram_a,
    output logic [DATA_W-1:0]          sram_di,
    input  logic [DATA_W-1:0]          sram_do
);

    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] addr_arr   [NUM_CH];
    logic [DATA_W-1:0] wdata_arr  [NUM_CH];
    logic [STRB_W-1:0] wstrb_arr  [NUM_CH];
    logic [DATA_W-1:0] rsp_data_q [NUM_CH];

    logic [NUM_CH-1:0] inflight;
    logic [NUM_CH-1:0] elig;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_vld;
    logic              grant_we;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign addr_arr[i]                   = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i]                  = req_wdata[i*DATA_W +: DATA_W];
        assign wstrb_arr[i]                  = req_wstrb[i*STRB_W +: STRB_W];
        assign rsp_data[i*DATA_W +: DATA_W]  = rsp_data_q[i];
    end

    // A read needs its buffer free (or draining this cycle) and no read already in the SRAM pipe.
    assign elig = req_valid & (req_we | (~inflight & (~rsp_valid | rsp_ready)));

    always_comb begin
        int cand;
        cand      = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (FIXED_PRIO != 0) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = PTR_W'(i);
                end
            end
        end else begin
            // Scan farthest-first so the candidate nearest ptr+1 is written last and wins.
            for (int k = NUM_CH; k >= 1; k--) begin
                cand = (int'(ptr) + k) % NUM_CH;
                if (elig[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = PTR_W'(cand);
                end
            end
        end
        if (!rst) begin
            grant_vld = 1'b0;
        end
    end

    assign grant_we  = req_we[grant_idx];
    assign req_ready = grant_vld ? (NUM_CH'(1) << grant_idx) : '0;

    always_comb begin
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_bweb = '1;
        sram_a    = '0;
        sram_di   = '0;
        if (grant_vld) begin
            sram_ceb = 1'b0;
            sram_web = ~grant_we;
            sram_a   = addr_arr[grant_idx];
            sram_di  = wdata_arr[grant_idx];
            for (int j = 0; j < STRB_W; j++) begin
                sram_bweb[j*8 +: 8] = {8{~(grant_we & wstrb_arr[grant_idx][j])}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight  <= '0;
            rsp_valid <= '0;
            ptr       <= PTR_W'(NUM_CH - 1);
            for (int i = 0; i < NUM_CH; i++) begin
                rsp_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                inflight[i] <= grant_vld && (grant_idx == PTR_W'(i)) && !grant_we;
                // Capture takes precedence over a same-cycle pop.
                if (inflight[i]) begin
                    rsp_valid[i]  <= 1'b1;
                    rsp_data_q[i] <= sram_do;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i]  <= 1'b0;
                end
            end
            if (FIXED_PRIO == 0 && grant_vld) begin
                ptr <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: per-cycle vector table plus hand sequences for ordering, backpressure, interleave and reset.
module tb_sram_arbiter;

    localparam logic [31:0] D0  = 32'hAABBCCDD;
    localparam logic [31:0] D1  = 32'h11223344;
    localparam logic [31:0] BW0 = 32'hFF00FF00;
    localparam logic [31:0] BW1 = 32'h00000000;
    localparam logic [31:0] BRD = 32'hFFFFFFFF;
    localparam logic [31:0] RB5 = 32'h00BB00DD;

    logic        clk, rst;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [27:0] req_addr;
    logic [63:0] req_wdata, rsp_data;
    logic [7:0]  req_wstrb;
    logic        sram_ceb, sram_web;
    logic [31:0] sram_bweb, sram_di, sram_do;
    logic [13:0] sram_a;

    logic [1:0]  fp_ready, fp_rsp_valid;
    logic [63:0] fp_rsp_data;
    logic        fp_ceb, fp_web;
    logic [31:0] fp_bweb, fp_di, fp_do;
    logic [13:0] fp_a;

    logic [13:0] a0, a1;
    logic [31:0] d0, d1;
    logic [3:0]  s0, s1;

    int checks = 0;
    int errors = 0;

    assign req_addr  = {a1, a0};
    assign req_wdata = {d1, d0};
    assign req_wstrb = {s1, s0};
    assign fp_do     = 32'h0;

    sram_arbiter #(.NUM_CH(2), .ADDR_W(14), .DATA_W(32), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb),
        .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
    );

    sram_arbiter #(.NUM_CH(2), .ADDR_W(14), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fp_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(fp_rsp_data),
        .sram_ceb(fp_ceb), .sram_web(fp_web), .sram_bweb(fp_bweb),
        .sram_a(fp_a), .sram_di(fp_di), .sram_do(fp_do)
    );

    // SRAM macro model: 1-cycle read latency, active-low bit write enables, unwritten words read as zero.
    logic [31:0] mem [logic [13:0]];

    function automatic logic [31:0] mem_rd(input logic [13:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web) mem[sram_a] = (mem_rd(sram_a) & sram_bweb) | (sram_di & ~sram_bweb);
            else           sram_do <= mem_rd(sram_a);
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [1:0]  vld, we, rrdy;
        logic [13:0] a0, a1;
        logic [1:0]  e_rdy;
        logic        e_ceb, e_web;
        logic [31:0] e_bweb;
        logic [13:0] e_a;
        logic [31:0] e_di;
        logic [1:0]  e_rvld;
        logic [31:0] e_rd0, e_rd1;
        logic [1:0]  e_fp;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge; return shortly before the next edge for sampling.
    task automatic drv(input logic r, input logic [1:0] v, input logic [1:0] w,
                       input logic [1:0] rr, input logic [13:0] x0, input logic [13:0] x1);
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        req_we    = w;
        rsp_ready = rr;
        a0        = x0;
        a1        = x1;
        #3;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_we = '0; rsp_ready = '0;
        a0 = '0; a1 = '0; d0 = D0; d1 = D1; s0 = 4'h5; s1 = 4'hF;
        #1 rst = 1'b0;

        //              rst   vld    we     rrdy   a0 a1 | rdy   ceb   web   bweb a  di  rvld   rd0 rd1 fp
        tbl[0]  = '{1'b0, 2'b11, 2'b00, 2'b00, 5, 9, 2'b00, 1'b1, 1'b1, BRD, 0, 0,  2'b00, 0,   0,  2'b00};
        tbl[1]  = '{1'b0, 2'b11, 2'b11, 2'b00, 5, 9, 2'b00, 1'b1, 1'b1, BRD, 0, 0,  2'b00, 0,   0,  2'b00};
        tbl[2]  = '{1'b1, 2'b11, 2'b11, 2'b00, 5, 9, 2'b01, 1'b0, 1'b0, BW0, 5, D0, 2'b00, 0,   0,  2'b01};
        tbl[3]  = '{1'b1, 2'b11, 2'b10, 2'b00, 5, 9, 2'b10, 1'b0, 1'b0, BW1, 9, D1, 2'b00, 0,   0,  2'b01};
        tbl[4]  = '{1'b1, 2'b11, 2'b00, 2'b00, 5, 9, 2'b01, 1'b0, 1'b1, BRD, 5, D0, 2'b00, 0,   0,  2'b10};
        tbl[5]  = '{1'b1, 2'b10, 2'b00, 2'b00, 5, 9, 2'b10, 1'b0, 1'b1, BRD, 9, D1, 2'b00, 0,   0,  2'b00};
        tbl[6]  = '{1'b1, 2'b00, 2'b00, 2'b00, 5, 9, 2'b00, 1'b1, 1'b1, BRD, 0, 0,  2'b01, RB5, 0,  2'b00};
        tbl[7]  = '{1'b1, 2'b00, 2'b00, 2'b01, 5, 9, 2'b00, 1'b1, 1'b1, BRD, 0, 0,  2'b11, RB5, D1, 2'b00};
        tbl[8]  = '{1'b1, 2'b00, 2'b00, 2'b10, 5, 9, 2'b00, 1'b1, 1'b1, BRD, 0, 0,  2'b10, RB5, D1, 2'b00};
        tbl[9]  = '{1'b1, 2'b11, 2'b11, 2'b11, 1, 2, 2'b01, 1'b0, 1'b0, BW0, 1, D0, 2'b00, RB5, D1, 2'b01};
        tbl[10] = '{1'b1, 2'b11, 2'b11, 2'b11, 1, 2, 2'b10, 1'b0, 1'b0, BW1, 2, D1, 2'b00, RB5, D1, 2'b01};
        tbl[11] = '{1'b1, 2'b11, 2'b11, 2'b11, 1, 2, 2'b01, 1'b0, 1'b0, BW0, 1, D0, 2'b00, RB5, D1, 2'b01};
        tbl[12] = '{1'b1, 2'b11, 2'b11, 2'b11, 1, 2, 2'b10, 1'b0, 1'b0, BW1, 2, D1, 2'b00, RB5, D1, 2'b01};
        tbl[13] = '{1'b1, 2'b00, 2'b00, 2'b11, 1, 2, 2'b00, 1'b1, 1'b1, BRD, 0, 0,  2'b00, RB5, D1, 2'b00};

        for (int i = 0; i < 14; i++) begin
            drv(tbl[i].rst, tbl[i].vld, tbl[i].we, tbl[i].rrdy, tbl[i].a0, tbl[i].a1);
            chk($sformatf("row%0d req_ready", i), 64'(req_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("row%0d sram_ceb", i),  64'(sram_ceb),  64'(tbl[i].e_ceb));
            chk($sformatf("row%0d sram_web", i),  64'(sram_web),  64'(tbl[i].e_web));
            chk($sformatf("row%0d sram_bweb", i), 64'(sram_bweb), 64'(tbl[i].e_bweb));
            chk($sformatf("row%0d sram_a", i),    64'(sram_a),    64'(tbl[i].e_a));
            chk($sformatf("row%0d sram_di", i),   64'(sram_di),   64'(tbl[i].e_di));
            chk($sformatf("row%0d rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].e_rvld));
            chk($sformatf("row%0d rsp_data0", i), 64'(rsp_data[31:0]),  64'(tbl[i].e_rd0));
            chk($sformatf("row%0d rsp_data1", i), 64'(rsp_data[63:32]), 64'(tbl[i].e_rd1));
            chk($sformatf("row%0d fp_ready", i),  64'(fp_ready),  64'(tbl[i].e_fp));
        end

        // Write then read of the same address on the very next cycle returns the new data.
        d0 = 32'h5A5A5A5A; s0 = 4'hF;
        drv(1'b1, 2'b01, 2'b01, 2'b11, 20, 20);
        chk("order wr grant", 64'(req_ready), 64'(2'b01));
        chk("order wr bweb",  64'(sram_bweb), 64'(BW1));
        drv(1'b1, 2'b10, 2'b00, 2'b11, 20, 20);
        chk("order rd grant", 64'(req_ready), 64'(2'b10));
        drv(1'b1, 2'b00, 2'b00, 2'b11, 20, 20);
        chk("order rvld T+1", 64'(rsp_valid), 64'(2'b00));
        drv(1'b1, 2'b00, 2'b00, 2'b11, 20, 20);
        chk("order rvld T+2", 64'(rsp_valid), 64'(2'b10));
        chk("order rdata",    64'(rsp_data[63:32]), 64'(32'h5A5A5A5A));

        // Untaken response stalls the channel's next read until the consumer is ready.
        drv(1'b1, 2'b10, 2'b00, 2'b00, 20, 20);
        chk("bp first grant", 64'(req_ready), 64'(2'b10));
        drv(1'b1, 2'b10, 2'b00, 2'b00, 20, 9);
        chk("bp inflight block", 64'(req_ready), 64'(2'b00));
        for (int c = 0; c < 5; c++) begin
            drv(1'b1, 2'b10, 2'b00, 2'b00, 20, 9);
            chk($sformatf("bp hold%0d ready", c), 64'(req_ready), 64'(2'b00));
            chk($sformatf("bp hold%0d rvld", c),  64'(rsp_valid), 64'(2'b10));
            chk($sformatf("bp hold%0d data", c),  64'(rsp_data[63:32]), 64'(32'h5A5A5A5A));
        end
        drv(1'b1, 2'b10, 2'b00, 2'b10, 20, 9);
        chk("bp release grant", 64'(req_ready), 64'(2'b10));
        chk("bp release addr",  64'(sram_a),    64'(14'd9));
        drv(1'b1, 2'b00, 2'b00, 2'b10, 20, 9);
        chk("bp second T+1", 64'(rsp_valid), 64'(2'b00));
        drv(1'b1, 2'b00, 2'b00, 2'b10, 20, 9);
        chk("bp second T+2", 64'(rsp_valid), 64'(2'b10));
        chk("bp second data", 64'(rsp_data[63:32]), 64'(D1));

        // Two channels reading back-to-back keep the SRAM busy every cycle.
        for (int c = 0; c < 6; c++) begin
            logic [1:0] er;
            logic [1:0] ev;
            er = c[0] ? 2'b10 : 2'b01;
            ev = (c < 2) ? 2'b00 : (c[0] ? 2'b10 : 2'b01);
            drv(1'b1, 2'b11, 2'b00, 2'b11, 5, 9);
            chk($sformatf("il%0d ready", c), 64'(req_ready), 64'(er));
            chk($sformatf("il%0d ceb", c),   64'(sram_ceb),  64'(1'b0));
            chk($sformatf("il%0d rvld", c),  64'(rsp_valid), 64'(ev));
        end
        chk("il rdata0", 64'(rsp_data[31:0]),  64'(RB5));
        chk("il rdata1", 64'(rsp_data[63:32]), 64'(D1));

        // Reset arriving just after a read grant discards everything and restarts at channel 0.
        drv(1'b1, 2'b01, 2'b00, 2'b11, 5, 9);
        chk("rst pre grant", 64'(req_ready), 64'(2'b01));
        chk("rst pre rvld",  64'(rsp_valid), 64'(2'b01));
        for (int c = 0; c < 2; c++) begin
            drv(1'b0, 2'b11, 2'b11, 2'b11, 1, 2);
            chk($sformatf("rst%0d ready", c), 64'(req_ready), 64'(2'b00));
            chk($sformatf("rst%0d ceb", c),   64'(sram_ceb),  64'(1'b1));
            chk($sformatf("rst%0d bweb", c),  64'(sram_bweb), 64'(BRD));
            chk($sformatf("rst%0d rvld", c),  64'(rsp_valid), 64'(2'b00));
            chk($sformatf("rst%0d rdata", c), rsp_data, 64'h0);
        end
        drv(1'b1, 2'b11, 2'b11, 2'b11, 1, 2);
        chk("post rst grant", 64'(req_ready), 64'(2'b01));
        chk("post rst rvld",  64'(rsp_valid), 64'(2'b00));
        drv(1'b1, 2'b00, 2'b00, 2'b11, 1, 2);
        chk("post rst rvld2", 64'(rsp_valid), 64'(2'b00));
        drv(1'b1, 2'b00, 2'b00, 2'b11, 1, 2);
        chk("post rst rvld3", 64'(rsp_valid), 64'(2'b00));
        chk("post rst rdata", rsp_data, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
